// File: rtl/snn_lif_layer.sv
// Layer of N_OUT leaky integrate-and-fire neurons over one shared binary input vector.
// Define SNN_REFRACTORY_EN to give each neuron a refractory counter of REFRAC_STEPS timesteps.
module snn_lif_layer #(
  parameter int N_IN         = 25,
  parameter int N_OUT        = 5,
  parameter int W_W          = 8,
  parameter int B_W          = 8,
  parameter int ACC_W        = 16,
  parameter int THRESH       = 64,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pulse,
  input  logic                        clear,
  input  logic [N_IN-1:0]             pixels_in,
  input  logic [N_OUT*N_IN*W_W-1:0]   weights_in,
  input  logic [N_OUT*B_W-1:0]        bias_in,
  output logic [N_OUT-1:0]            spike,
  output logic                        spike_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam int EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] V_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] V_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] V_THR = ACC_W'(THRESH);

  typedef enum logic [1:0] {IDLE, LEAK, ACCUM, FIRE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [N_IN-1:0]         pix_q;
  logic signed [ACC_W-1:0] v     [N_OUT];
  logic signed [W_W-1:0]   w_sel [N_OUT];
  logic signed [B_W-1:0]   b_sel [N_OUT];
  logic [N_OUT-1:0]        frozen;
  logic [N_OUT-1:0]        fire;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] x);
    if (x > V_MAX) return V_MAX[ACC_W-1:0];
    if (x < V_MIN) return V_MIN[ACC_W-1:0];
    return x[ACC_W-1:0];
  endfunction

  // Arithmetic shift makes the leak round toward minus infinity.
  function automatic logic signed [ACC_W-1:0] leak_bias(input logic signed [ACC_W-1:0] x,
                                                        input logic signed [B_W-1:0]   b);
    logic signed [ACC_W-1:0] decay;
    decay = x >>> LEAK_SHIFT;
    return sat(EXT_W'(x) - EXT_W'(decay) + EXT_W'(b));
  endfunction

  function automatic logic signed [ACC_W-1:0] add_weight(input logic signed [ACC_W-1:0] x,
                                                         input logic signed [W_W-1:0]   w);
    return sat(EXT_W'(x) + EXT_W'(w));
  endfunction

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      w_sel[j] = weights_in[(j*N_IN + int'(idx))*W_W +: W_W];
      b_sel[j] = bias_in[j*B_W +: B_W];
      fire[j]  = !frozen[j] && (v[j] >= V_THR);
    end
  end

`ifdef SNN_REFRACTORY_EN
  localparam int R_W = (REFRAC_STEPS > 1) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [R_W-1:0] R_INIT = R_W'(REFRAC_STEPS);

  logic [R_W-1:0] r [N_OUT];

  always_comb begin
    for (int j = 0; j < N_OUT; j++) frozen[j] = (r[j] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_OUT; j++) r[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j < N_OUT; j++) r[j] <= '0;
    end else if (state == FIRE) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (frozen[j])    r[j] <= r[j] - R_W'(1);
        else if (fire[j]) r[j] <= R_INIT;
      end
    end
  end
`else
  logic unused_refrac;
  assign frozen        = '0;
  assign unused_refrac = (REFRAC_STEPS != 0);
`endif

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (pulse) state_nxt = LEAK;
        LEAK:    state_nxt = ACCUM;
        ACCUM:   if (idx == IDX_LAST) state_nxt = FIRE;
        FIRE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Input capture: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && pulse && !clear) pix_q <= pixels_in;
  end

  // Membrane update: leak+bias, one input per cycle, then threshold with reset-by-subtraction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      spike <= '0;
      for (int j = 0; j < N_OUT; j++) v[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j < N_OUT; j++) v[j] <= '0;
    end else begin
      case (state)
        LEAK: begin
          idx <= '0;
          for (int j = 0; j < N_OUT; j++)
            if (!frozen[j]) v[j] <= leak_bias(v[j], b_sel[j]);
        end
        ACCUM: begin
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          if (pix_q[idx])
            for (int j = 0; j < N_OUT; j++)
              if (!frozen[j]) v[j] <= add_weight(v[j], w_sel[j]);
        end
        FIRE: begin
          spike <= fire;
          for (int j = 0; j < N_OUT; j++)
            if (fire[j]) v[j] <= v[j] - V_THR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      spike_valid <= (state == FIRE) && !clear;
      busy        <= (state_nxt != IDLE);
      overrun     <= pulse && !clear && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Bench for snn_lif_layer: two instances (ACC_W 16 and 12) against an integer timestep model.
module tb_snn_lif_layer;

  localparam int N_IN = 25, N_OUT = 5, W_W = 8, B_W = 8;
  localparam int THRESH = 64, LEAK_SHIFT = 3, REFRAC_STEPS = 2;
  localparam int LAST = N_IN + 2;

  logic clk = 1'b0;
  logic reset, pulse, clear;
  logic [N_IN-1:0]           pixels_in;
  logic [N_OUT*N_IN*W_W-1:0] weights_in;
  logic [N_OUT*B_W-1:0]      bias_in;
  logic [N_OUT-1:0]          spike_a, spike_b;
  logic                      sv_a, sv_b, busy_a, busy_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  snn_lif_layer #(.ACC_W(16)) dut_a (
    .clk(clk), .reset(reset), .pulse(pulse), .clear(clear), .pixels_in(pixels_in),
    .weights_in(weights_in), .bias_in(bias_in), .spike(spike_a), .spike_valid(sv_a),
    .busy(busy_a), .overrun(ovr_a));

  snn_lif_layer #(.ACC_W(12)) dut_b (
    .clk(clk), .reset(reset), .pulse(pulse), .clear(clear), .pixels_in(pixels_in),
    .weights_in(weights_in), .bias_in(bias_in), .spike(spike_b), .spike_valid(sv_b),
    .busy(busy_b), .overrun(ovr_b));

  int n_cmp = 0;
  int n_bad = 0;
  int wt [N_OUT][N_IN];
  int bs [N_OUT];
  int acc_w [2] = '{16, 12};
  int mv [2][N_OUT];
  int mr [2][N_OUT];
  int nv [2][N_OUT];
  int nr [2][N_OUT];
  logic [N_OUT-1:0] mspk [2];
  logic [N_OUT-1:0] nspk [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic eb, input logic esv, input logic eo);
    check_eq({tag, " a:busy/sv/ovr"}, 32'({busy_a, sv_a, ovr_a}), 32'({eb, esv, eo}));
    check_eq({tag, " b:busy/sv/ovr"}, 32'({busy_b, sv_b, ovr_b}), 32'({eb, esv, eo}));
  endtask

  task automatic check_spk(input string tag, input logic [N_OUT-1:0] ea, input logic [N_OUT-1:0] eb);
    check_eq({tag, " a:spike"}, 32'(spike_a), 32'(ea));
    check_eq({tag, " b:spike"}, 32'(spike_b), 32'(eb));
  endtask

  function automatic int sat_m(int x, int aw);
    int hi, lo;
    hi = (1 << (aw - 1)) - 1;
    lo = -(1 << (aw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int floor_div(int x, int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  task automatic model_zero(input bit spikes_too);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < N_OUT; j++) begin
        mv[k][j] = 0;
        mr[k][j] = 0;
      end
      if (spikes_too) mspk[k] = '0;
    end
  endtask

  task automatic model_step(input logic [N_IN-1:0] pix);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < N_OUT; j++) begin
        int v, r;
        bit frz;
        v = mv[k][j];
        r = mr[k][j];
        frz = 1'b0;
`ifdef SNN_REFRACTORY_EN
        frz = (r > 0);
`endif
        if (!frz) begin
          v = sat_m(v - floor_div(v, 1 << LEAK_SHIFT) + bs[j], acc_w[k]);
          for (int i = 0; i < N_IN; i++)
            if (pix[i]) v = sat_m(v + wt[j][i], acc_w[k]);
        end
        nspk[k][j] = 1'b0;
        if (frz) r--;
        else if (v >= THRESH) begin
          nspk[k][j] = 1'b1;
          v -= THRESH;
          r = REFRAC_STEPS;
        end
        nv[k][j] = v;
        nr[k][j] = r;
      end
    end
  endtask

  task automatic load_params();
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) weights_in[(j*N_IN + i)*W_W +: W_W] = W_W'(wt[j][i]);
      bias_in[j*B_W +: B_W] = B_W'(bs[j]);
    end
  endtask

  task automatic set_uniform(input int w, input int b);
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) wt[j][i] = w;
      bs[j] = b;
    end
    load_params();
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_ctl(tag, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after FIRE (or after clear).
  task automatic run_step(input logic [N_IN-1:0] pix, input int ovr_at, input int clr_at,
                          input string tag);
    bit aborted;
    aborted = 1'b0;
    model_step(pix);
    pixels_in = pix;
    pulse = 1'b1;
    clear = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      @(negedge clk);
      pulse = 1'b0;
      clear = 1'b0;
      if (clr_at > 0 && k == clr_at) aborted = 1'b1;
      if (aborted) check_ctl($sformatf("%s e%0d", tag, k), 1'b0, 1'b0, 1'b0);
      else check_ctl($sformatf("%s e%0d", tag, k), k != LAST, k == LAST, ovr_at > 0 && k == ovr_at);
      if (aborted) break;
      pulse = (k + 1 == ovr_at);
      clear = (k + 1 == clr_at);
    end
    if (aborted) begin
      check_spk({tag, " held"}, mspk[0], mspk[1]);
      model_zero(1'b0);
    end else begin
      check_spk(tag, nspk[0], nspk[1]);
      mv = nv;
      mr = nr;
      mspk = nspk;
    end
  endtask

  initial begin
    logic [N_IN-1:0] pix;
    int ovr_at, clr_at, wmax, bmax;

    reset = 1'b1; pulse = 1'b0; clear = 1'b0;
    pixels_in = '0; weights_in = '0; bias_in = '0;
    model_zero(1'b1);
    repeat (2) @(negedge clk);
    check_eq("reset a", 32'({spike_a, sv_a, busy_a, ovr_a}), 32'd0);
    check_eq("reset b", 32'({spike_b, sv_b, busy_b, ovr_b}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Integrate and fire, four back-to-back timesteps.
    set_uniform(8, 0);
    run_step('1, 0, 0, "if1");
    check_eq("if1 all fire", 32'(spike_a), 32'(5'b11111));
    run_step('1, 0, 0, "if2");
    run_step('1, 0, 0, "if3");
    run_step('1, 0, 0, "if4");
    idle_cycles(2, "if idle");

    // clear together with pulse: dropped, no busy, no overrun, spike held.
    pulse = 1'b1; clear = 1'b1;
    @(negedge clk);
    pulse = 1'b0; clear = 1'b0;
    check_ctl("clr+pulse", 1'b0, 1'b0, 1'b0);
    check_spk("clr+pulse held", mspk[0], mspk[1]);
    model_zero(1'b0);
    idle_cycles(2, "clr idle");

    // Subthreshold then fire.
    set_uniform(2, 0);
    run_step('1, 0, 0, "sub1");
    check_eq("sub1 silent", 32'(spike_a), 32'd0);
    run_step('1, 0, 0, "sub2");
    check_eq("sub2 fire", 32'(spike_a), 32'(5'b11111));
    idle_cycles(1, "sub idle");

    // Saturation low, then high.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero(1'b0);
    set_uniform(-128, -128);
    for (int s = 0; s < 3; s++) run_step('1, 0, 0, $sformatf("satlo%0d", s));
    check_eq("satlo b silent", 32'(spike_b), 32'd0);
    set_uniform(127, 127);
    for (int s = 0; s < 3; s++) run_step('1, 0, 0, $sformatf("sathi%0d", s));
    idle_cycles(1, "sat idle");

    // Overrun pulse at E10 and at the FIRE edge.
    set_uniform(8, 0);
    run_step('1, 10, 0, "ovr10");
    idle_cycles(1, "ovr idle");
    run_step('1, LAST, 0, "ovrfire");
    idle_cycles(1, "ovr idle2");

    // Reset in the middle of accumulation.
    pixels_in = '1; pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midreset a", 32'({spike_a, sv_a, busy_a, ovr_a}), 32'd0);
    check_eq("midreset b", 32'({spike_b, sv_b, busy_b, ovr_b}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_zero(1'b1);
    idle_cycles(N_IN + 4, "post reset");
    run_step('1, 0, 0, "after reset");
    check_eq("after reset fire", 32'(spike_a), 32'(5'b11111));
    idle_cycles(1, "ar idle");

    // Randomized timesteps.
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 2))
        0: wmax = 4;
        1: wmax = 24;
        default: wmax = 128;
      endcase
      bmax = ($urandom_range(0, 1) == 0) ? 8 : 128;
      for (int j = 0; j < N_OUT; j++) begin
        for (int i = 0; i < N_IN; i++) begin
          wt[j][i] = int'($urandom_range(0, 2*wmax)) - wmax;
          if (wt[j][i] > 127) wt[j][i] = 127;
        end
        bs[j] = int'($urandom_range(0, 2*bmax)) - bmax;
        if (bs[j] > 127) bs[j] = 127;
      end
      load_params();
      pix = N_IN'($urandom);
      ovr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAST)) : 0;
      clr_at = 0;
      if ($urandom_range(0, 5) == 0)
        clr_at = int'($urandom_range((ovr_at > 0) ? ovr_at : 1, LAST));
      run_step(pix, ovr_at, clr_at, $sformatf("rnd%0d", s));
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 3)), "rnd idle");
    end
    idle_cycles(2, "end idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_lif_layer.md
# snn_lif_layer

Parametrised spiking layer of N_OUT leaky integrate-and-fire neurons sharing one binary input vector of N_IN pixels. Each `pulse` launches one timestep: leak plus bias, then serial accumulation over inputs (all neurons in parallel, one input per cycle), then threshold/fire. It replaces fixed 25-input/5-neuron layers. Its `spike` vector feeds the next layer's `pixels_in`.

## Interface
- N_IN, 25, number of binary inputs.
- N_OUT, 5, number of neurons.
- W_W, 8, signed weight width.
- B_W, 8, signed bias width.
- ACC_W, 16, signed membrane width. Must satisfy ACC_W > W_W + clog2(N_IN).
- THRESH, 64, positive firing threshold.
- LEAK_SHIFT, 3, leak divisor exponent.
- REFRAC_STEPS, 2, refractory timesteps. Used only with SNN_REFRACTORY_EN.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pulse  in  1  timestep strobe; accepted only in IDLE.
- clear  in  1  synchronous; zeroes membranes and aborts any in-progress timestep.
- pixels_in  in  N_IN  binary input vector, latched when `pulse` is accepted.
- weights_in  in  N_OUT*N_IN*W_W  weight for neuron j, input i at bits [(j*N_IN+i)*W_W +: W_W]. Must be held stable while busy.
- bias_in  in  N_OUT*B_W  bias for neuron j at bits [j*B_W +: B_W].
- spike  out  N_OUT  spike result of the last completed timestep; held until the next FIRE.
- spike_valid  out  1  one-cycle strobe when `spike` updates.
- busy  out  1  high from the cycle after `pulse` is accepted until the cycle after FIRE.
- overrun  out  1  one-cycle strobe when `pulse` arrives while busy.

## Operation
- FSM states: IDLE, LEAK, ACCUM, FIRE.
- IDLE:
  - On `pulse`: latch `pixels_in`, go to LEAK.
- LEAK:
  - For each neuron j: v_j = sat(v_j − (v_j >>> LEAK_SHIFT) + sext(bias_j)).
  - Clear input index idx to 0. Go to ACCUM.
- ACCUM:
  - Each cycle, if pixel[idx]=1: v_j = sat(v_j + sext(w_j,idx)) for every j.
  - Increment idx. After idx = N_IN−1, go to FIRE.
- FIRE:
  - For each j: spike_j = (v_j ≥ THRESH).
  - If spike_j, v_j = v_j − THRESH (reset by subtraction).
  - Pulse `spike_valid`. Go to IDLE.
- sat(): clamp to signed ACC_W limits [−2^(ACC_W−1), 2^(ACC_W−1)−1]. No wrap-around, ever.
- `>>>` is an arithmetic shift, so the leak rounds toward −∞.
- `pulse` while not IDLE: ignored, `overrun`=1 for one cycle, no other effect.
- `clear`:
  - Next edge: all v_j=0, refractory counters=0, state=IDLE.
  - No `spike_valid` is issued; `spike` holds its value.
  - `clear` wins over a simultaneous `pulse`; that `pulse` is dropped and `overrun` is not raised.
- `reset` (at any time, including mid-ACCUM):
  - state=IDLE, v_j=0, idx=0, refractory counters=0.
  - spike=0, spike_valid=0, busy=0, overrun=0.

## Timing
- `pulse` sampled at edge E0. LEAK at E1. ACCUM at E2..E(N_IN+1). FIRE at E(N_IN+2).
- Latency: `spike`/`spike_valid` visible N_IN+2 cycles after the pulse edge (27 at defaults).
- `busy`: high after E0, low after E(N_IN+2).
- A `pulse` coincident with `spike_valid` is accepted (FSM is IDLE). Minimum timestep period is N_IN+2 cycles.
- All outputs are registered. Reset values are all zero.

## Configuration
- Macro `SNN_REFRACTORY_EN`:
  - Defined: each neuron has a counter r_j. On a spike at FIRE, r_j = REFRAC_STEPS. While r_j>0, LEAK and ACCUM leave v_j unchanged, and at FIRE spike_j=0 and r_j decrements.
  - Undefined: no counters, REFRAC_STEPS ignored, neurons may fire every timestep.

## Test plan
- Integrate and fire:
  - Stimulus: all weights +8, bias 0, pixels all 1, one pulse.
  - Response: spike=5'b11111 at cycle 27, v=136.
  - Second pulse: v=136−17+200=319 → spike, v=255.
- Subthreshold:
  - Stimulus: weights +2, pixels all 1, bias 0.
  - Response: step 1 v=50, spike=0. Step 2 v=50−6+50=94 → spike=1, v=30.
- Saturation:
  - Stimulus: ACC_W=12, weights −128, pixels all 1.
  - Response: v clamps at −2048 with no wrap, spike=0.
  - Then weights +127 for 3 pulses: v never exceeds 2047.
- Overrun:
  - Stimulus: pulse at E0 and again at E10.
  - Response: overrun high exactly one cycle, after E10. Exactly one spike_valid, at cycle 27.
- Reset and clear:
  - Assert reset during ACCUM (idx=12): all outputs 0, no spike_valid afterwards, next pulse behaves as the first pulse of the integrate-and-fire case.
  - clear together with pulse: membranes 0, busy stays 0, overrun stays 0.
- Refractory (SNN_REFRACTORY_EN, REFRAC_STEPS=2):
  - Stimulus: the integrate-and-fire stimulus, 4 pulses.
  - Response: spike pattern 1,0,0,1 per neuron. v is frozen at 136 during steps 2–3.
  - Without the macro: pattern 1,1,1,1.
